// File: rtl/slot_pkg.sv
// Shared types, defaults and combination helpers for the reel spin controller.
package slot_pkg;

    localparam int unsigned SYMW_DEF  = 3;
    localparam int unsigned NSYM_DEF  = 6;
    localparam int unsigned SYMW_MAX  = 8;
    localparam int unsigned MAXREELS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        EVAL = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic win;
        logic jackpot;
    } match_t;

    // Out-of-range RNG values collapse onto the highest legal symbol.
    function automatic logic [SYMW_MAX-1:0] clamp_sym(input logic [SYMW_MAX-1:0] v,
                                                      input int unsigned         nsym);
        if (32'(v) < nsym) begin
            return v;
        end
        return SYMW_MAX'(nsym - 1);
    endfunction

    // Any equal pair is a win; all reels equal to reel 0 is a jackpot.
    function automatic match_t eval_match(input logic [MAXREELS*SYMW_MAX-1:0] r,
                                          input int unsigned                  n);
        match_t m;
        m.win     = 1'b0;
        m.jackpot = 1'b1;
        for (int unsigned i = 0; i < MAXREELS; i++) begin
            for (int unsigned j = 0; j < MAXREELS; j++) begin
                if (i < j && j < n &&
                    r[i*SYMW_MAX +: SYMW_MAX] == r[j*SYMW_MAX +: SYMW_MAX]) begin
                    m.win = 1'b1;
                end
            end
        end
        for (int unsigned i = 1; i < MAXREELS; i++) begin
            if (i < n && r[i*SYMW_MAX +: SYMW_MAX] != r[SYMW_MAX-1:0]) begin
                m.jackpot = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/reel_slot.sv
// One reel: follows the clamped RNG symbol while spinning, freezes on its stop strobe.
module reel_slot #(
    parameter int unsigned SYMW = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            run_i,
    input  logic            stop_i,
    input  logic [SYMW-1:0] sym_i,
    output logic [SYMW-1:0] sym_o,
    output logic            stopped_o
);

    logic stopped_q;
    logic stopped_d;
    logic load_c;

    // The stopping edge itself still loads, so the frozen value is the one sampled there.
    assign load_c = run_i && !stopped_q;

    vDFFRL #(.n(SYMW)) u_sym (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (load_c),
        .d_i  (sym_i),
        .q_o  (sym_o)
    );

    // Stopped flag is cleared when a new spin is accepted.
    always_comb begin
        stopped_d = stopped_q;
        if (clear_i) begin
            stopped_d = 1'b0;
        end else if (stop_i) begin
            stopped_d = 1'b1;
        end
    end

    // Stopped flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stopped_q <= 1'b0;
        end else begin
            stopped_q <= stopped_d;
        end
    end

    assign stopped_o = stopped_q;

endmodule

// File: rtl/vDFFRL.sv
// Load-enabled register with synchronous active-high reset.
module vDFFRL #(
    parameter int unsigned n = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [n-1:0] d_i,
    output logic [n-1:0] q_o
);

    // Clear on reset, otherwise capture on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= '0;
        end else if (load) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/reel_spin_controller.sv
// Spin sequencer: runs the reels, stops them at a fixed cadence, then scores the result.
module reel_spin_controller
    import slot_pkg::*;
#(
    parameter int unsigned NREELS     = 3,
    parameter int unsigned SYMW       = SYMW_DEF,
    parameter int unsigned NSYM       = NSYM_DEF,
    parameter int unsigned STOP_DELAY = 8,
    parameter int unsigned CNTW       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spin,
    input  logic [SYMW-1:0]        rng_val,
    output logic                   busy,
    output logic [NREELS-1:0]      reel_stopped,
    output logic [NREELS*SYMW-1:0] reels,
    output logic                   done,
    output logic                   win,
    output logic                   jackpot
);

    localparam int unsigned IDXW = (NREELS > 1) ? $clog2(NREELS) : 1;

    ctrl_state_t state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            busy_q, done_q, win_q, jackpot_q;

    logic            start_c, run_c, stop_c, eval_c;
    logic [SYMW-1:0] sym_c;
    logic [MAXREELS*SYMW_MAX-1:0] pad_c;
    match_t          match_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (spin) state_d = SPIN;
            SPIN: if (stop_c && idx_q == IDXW'(NREELS - 1)) state_d = EVAL;
            EVAL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes derived from the current state.
    always_comb begin
        start_c = 1'b0;
        run_c   = 1'b0;
        stop_c  = 1'b0;
        eval_c  = 1'b0;
        case (state_q)
            IDLE: start_c = spin;
            SPIN: begin
                run_c  = 1'b1;
                stop_c = (cnt_q == CNTW'(STOP_DELAY - 1));
            end
            EVAL: eval_c = 1'b1;
            default: ;
        endcase
    end

    // Stop-cadence counter and index of the next reel to freeze.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (start_c) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (run_c) begin
            if (stop_c) begin
                cnt_d = '0;
                idx_d = idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Shared clamp of the live RNG value feeding every reel.
    assign sym_c = SYMW'(clamp_sym(SYMW_MAX'(rng_val), NSYM));

    for (genvar i = 0; i < NREELS; i++) begin : g_reel
        reel_slot #(.SYMW(SYMW)) u_reel (
            .clk_i     (clk),
            .rst_i     (rst),
            .clear_i   (start_c),
            .run_i     (run_c),
            .stop_i    (stop_c && idx_q == IDXW'(i)),
            .sym_i     (sym_c),
            .sym_o     (reels[i*SYMW +: SYMW]),
            .stopped_o (reel_stopped[i])
        );
    end

    // Widen the reel bus to the fixed layout the scoring helper expects.
    always_comb begin
        pad_c = '0;
        for (int unsigned i = 0; i < NREELS; i++) begin
            pad_c[i*SYMW_MAX +: SYMW_MAX] = SYMW_MAX'(reels[i*SYMW +: SYMW]);
        end
        match_c = eval_match(pad_c, NREELS);
    end

    // Result, done pulse and busy flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            jackpot_q <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= eval_c;
            if (start_c) begin
                win_q     <= 1'b0;
                jackpot_q <= 1'b0;
            end else if (eval_c) begin
                win_q     <= match_c.win;
                jackpot_q <= match_c.jackpot;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign win     = win_q;
    assign jackpot = jackpot_q;

endmodule

// File: tb/tb_reel_spin_controller.sv
// Bench for reel_spin_controller: directed table, hand sequences and randomized spins.
module tb_reel_spin_controller;

    localparam int unsigned NREELS = 3;
    localparam int unsigned SYMW   = 3;
    localparam int unsigned NSYM   = 6;
    localparam int unsigned SD     = 4;
    localparam int unsigned LAST   = NREELS * SD;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   spin;
    logic [SYMW-1:0]        rng_val;
    logic                   busy;
    logic [NREELS-1:0]      reel_stopped;
    logic [NREELS*SYMW-1:0] reels;
    logic                   done;
    logic                   win;
    logic                   jackpot;

    int checks = 0;
    int errors = 0;

    logic [SYMW-1:0] exp_r [NREELS];
    logic            exp_win, exp_jack;

    typedef struct {
        logic [NREELS*SYMW-1:0] stops;
        logic [NREELS*SYMW-1:0] final_reels;
        logic                   w;
        logic                   j;
    } vec_t;

    vec_t tbl [5];

    reel_spin_controller #(
        .NREELS(NREELS), .SYMW(SYMW), .NSYM(NSYM), .STOP_DELAY(SD), .CNTW(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spin         (spin),
        .rng_val      (rng_val),
        .busy         (busy),
        .reel_stopped (reel_stopped),
        .reels        (reels),
        .done         (done),
        .win          (win),
        .jackpot      (jackpot)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SYMW-1:0] clamp_m(input logic [SYMW-1:0] v);
        return (int'(v) >= int'(NSYM)) ? SYMW'(NSYM - 1) : v;
    endfunction

    // Scoring straight from the rules: any equal pair wins, all equal is a jackpot.
    task automatic score_model();
        exp_win  = 1'b0;
        exp_jack = 1'b1;
        for (int i = 0; i < NREELS; i++)
            for (int j = i + 1; j < NREELS; j++)
                if (exp_r[i] == exp_r[j]) exp_win = 1'b1;
        for (int i = 1; i < NREELS; i++)
            if (exp_r[i] != exp_r[0]) exp_jack = 1'b0;
    endtask

    // One full spin from the accepting edge (edge 0) through one idle edge after done.
    task automatic do_spin(input logic [NREELS*SYMW-1:0] sv, input bit repulse, input bit hold);
        logic [SYMW-1:0]   r;
        logic [NREELS-1:0] mask;
        spin = 1'b1;
        rng_val = SYMW'($urandom_range(0, 7));
        step();
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_stopped", 32'(reel_stopped), 32'd0);
        chk("accept_done", 32'(done), 32'd0);
        chk("accept_win", 32'(win), 32'd0);
        chk("accept_jackpot", 32'(jackpot), 32'd0);
        if (!hold) spin = 1'b0;
        for (int e = 1; e <= int'(LAST) + 1; e++) begin
            if (repulse) spin = (e == 2 || e == 9);
            if (e % int'(SD) == 0 && e <= int'(LAST))
                r = sv[(e / int'(SD) - 1) * int'(SYMW) +: SYMW];
            else
                r = SYMW'($urandom_range(0, 7));
            rng_val = r;
            step();
            mask = '0;
            for (int i = 0; i < NREELS; i++) begin
                if (e <= (i + 1) * int'(SD)) exp_r[i] = clamp_m(r);
                if (e >= (i + 1) * int'(SD)) mask[i] = 1'b1;
            end
            chk("stopped", 32'(reel_stopped), 32'(mask));
            chk("busy", 32'(busy), (e <= int'(LAST)) ? 32'd1 : 32'd0);
            chk("done", 32'(done), (e == int'(LAST) + 1) ? 32'd1 : 32'd0);
            for (int i = 0; i < NREELS; i++)
                chk("reel", 32'(reels[i*SYMW +: SYMW]), 32'(exp_r[i]));
            if (e <= int'(LAST)) begin
                chk("win_early", 32'(win), 32'd0);
                chk("jackpot_early", 32'(jackpot), 32'd0);
            end else begin
                score_model();
                chk("win", 32'(win), 32'(exp_win));
                chk("jackpot", 32'(jackpot), 32'(exp_jack));
            end
        end
        spin = hold;
        rng_val = SYMW'($urandom_range(0, 7));
        step();
        chk("post_done", 32'(done), 32'd0);
        if (hold) begin
            chk("rearm_busy", 32'(busy), 32'd1);
            chk("rearm_win", 32'(win), 32'd0);
            chk("rearm_jackpot", 32'(jackpot), 32'd0);
            chk("rearm_stopped", 32'(reel_stopped), 32'd0);
        end else begin
            chk("post_busy", 32'(busy), 32'd0);
            chk("hold_win", 32'(win), 32'(exp_win));
            chk("hold_jackpot", 32'(jackpot), 32'(exp_jack));
            for (int i = 0; i < NREELS; i++)
                chk("hold_reel", 32'(reels[i*SYMW +: SYMW]), 32'(exp_r[i]));
        end
        spin = 1'b0;
    endtask

    initial begin
        // Stop values packed reel 0 in the low digit (octal: one digit per reel).
        tbl[0] = '{9'o222, 9'o222, 1'b1, 1'b1};
        tbl[1] = '{9'o131, 9'o131, 1'b1, 1'b0};
        tbl[2] = '{9'o210, 9'o210, 1'b0, 1'b0};
        tbl[3] = '{9'o777, 9'o555, 1'b1, 1'b1};
        tbl[4] = '{9'o056, 9'o055, 1'b1, 1'b0};

        rst = 1'b1;
        spin = 1'b0;
        rng_val = '0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reels", 32'(reels), 32'd0);
        chk("rst_stopped", 32'(reel_stopped), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_win", 32'(win), 32'd0);
        chk("rst_jackpot", 32'(jackpot), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed table.
        for (int t = 0; t < 5; t++) begin
            do_spin(tbl[t].stops, 1'b0, 1'b0);
            chk("tbl_reels", 32'(reels), 32'(tbl[t].final_reels));
            chk("tbl_win", 32'(win), 32'(tbl[t].w));
            chk("tbl_jackpot", 32'(jackpot), 32'(tbl[t].j));
        end

        // Spin re-requested mid-run is ignored.
        do_spin(9'o123, 1'b1, 1'b0);

        // Randomized spins against the model.
        for (int n = 0; n < 20; n++)
            do_spin(9'($urandom()), 1'b0, 1'b0);

        // Spin held high re-arms on the done cycle, then reset aborts the new run.
        do_spin(9'o444, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        step();

        // Reset mid-spin at edge 6, fresh spin at edge 10.
        spin = 1'b1;
        step();
        spin = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            rng_val = SYMW'($urandom_range(0, 7));
            step();
        end
        rst = 1'b1;
        step();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_reels", 32'(reels), 32'd0);
        chk("midrst_stopped", 32'(reel_stopped), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        for (int e = 7; e <= 9; e++) begin
            step();
            chk("midrst_idle_done", 32'(done), 32'd0);
            chk("midrst_idle_busy", 32'(busy), 32'd0);
        end
        do_spin(9'o333, 1'b0, 1'b0);
        chk("after_rst_jackpot", 32'(jackpot), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
